display_scan_controller: RTL and testbench

//  Time-multiplexes one hexadecimalLED decoder across NUM_DIGITS common-anode digits of a 7-segment bank.
//  - Holds a NUM_DIGITS-nibble display value in a shadow register.
//  - Cycles a one-hot digit select, driving the nibble for the selected digit to the decoder.
//  - Inserts a blanking gap between digits to prevent ghosting.
//  - Applies value updates only at frame boundaries, so a multi-digit number never tears.
//  - Sits between system logic (value producer) and the decoder/anode pins.

---
 rtl/display_scan_controller.sv | 146 ++++++++++++++
 tb/tb_display_scan_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller: scans one shared hex nibble across NUM_DIGITS
// common-anode 7-segment digits, with a blanking gap before each digit
// and frame-synchronous value updates so multi-digit numbers never tear.
module display_scan_controller #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned ON_CYC     = 50000,
  parameter int unsigned BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    habilitar,
  input  logic [4*NUM_DIGITS-1:0] valor,
  input  logic                    actualizar,
  input  logic                    suprimir_ceros,
  output logic [3:0]              numeroMostrar,
  output logic [NUM_DIGITS-1:0]   anodo,
  output logic                    ocupado,
  output logic                    fin_trama
);

  localparam int unsigned DATA_W  = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_MAX = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } estado_t;

  estado_t           estado, estado_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] shadow, shadow_n;
  logic [DATA_W-1:0] pend_val, pend_val_n;
  logic              pend, pend_n;

  logic                  wrap;
  logic                  apply_upd;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  blank_digit;

  // upper_zero[i] = shadow nibbles i..NUM_DIGITS-1 are all zero
  always_comb begin
    zero_run   = 1'b1;
    upper_zero = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run      = zero_run & (shadow[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end
  end

  // Output decode from scan state and shadow value
  always_comb begin
    wrap          = (estado == S_ON) && (cnt == ON_LAST) && (idx == IDX_LAST);
    blank_digit   = suprimir_ceros && (idx != '0) && upper_zero[idx];
    numeroMostrar = shadow[{idx, 2'b00} +: 4];
    ocupado       = pend;
    fin_trama     = habilitar && wrap;
    anodo         = '0;
    if (habilitar && (estado == S_ON) && !blank_digit) begin
      anodo = NUM_DIGITS'(1) << idx;
    end
  end

  // Next-state: scan sequencing and update handshake
  always_comb begin
    estado_n   = estado;
    idx_n      = idx;
    cnt_n      = cnt;
    shadow_n   = shadow;
    pend_val_n = pend_val;
    pend_n     = pend;
    apply_upd  = !habilitar || wrap;

    if (!habilitar) begin
      estado_n = S_BLANK;
      idx_n    = '0;
      cnt_n    = '0;
    end else begin
      case (estado)
        S_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_n    = '0;
            estado_n = S_ON;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        S_ON: begin
          if (cnt == ON_LAST) begin
            cnt_n    = '0;
            estado_n = S_BLANK;
            idx_n    = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        default: begin
          estado_n = S_BLANK;
          cnt_n    = '0;
          idx_n    = '0;
        end
      endcase
    end

    // A strobe coinciding with an apply point goes straight to the display
    if (actualizar) begin
      pend_val_n = valor;
    end
    if (apply_upd && actualizar) begin
      shadow_n = valor;
      pend_n   = 1'b0;
    end else if (apply_upd && pend) begin
      shadow_n = pend_val;
      pend_n   = 1'b0;
    end else if (actualizar) begin
      pend_n = 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      estado   <= S_BLANK;
      idx      <= '0;
      cnt      <= '0;
      shadow   <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
    end else begin
      estado   <= estado_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      shadow   <= shadow_n;
      pend_val <= pend_val_n;
      pend     <= pend_n;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller (NUM_DIGITS=4, ON_CYC=4, BLANK_CYC=2).
module tb_display_scan_controller;

  localparam int N     = 4;
  localparam int ON    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = ON + BL;
  localparam int FRAME = N * SLOT;

  logic        clk;
  logic        rst;
  logic        habilitar;
  logic [15:0] valor;
  logic        actualizar;
  logic        suprimir_ceros;
  logic [3:0]  numeroMostrar;
  logic [3:0]  anodo;
  logic        ocupado;
  logic        fin_trama;

  display_scan_controller #(.NUM_DIGITS(N), .ON_CYC(ON), .BLANK_CYC(BL)) dut (
    .clk            (clk),
    .rst            (rst),
    .habilitar      (habilitar),
    .valor          (valor),
    .actualizar     (actualizar),
    .suprimir_ceros (suprimir_ceros),
    .numeroMostrar  (numeroMostrar),
    .anodo          (anodo),
    .ocupado        (ocupado),
    .fin_trama      (fin_trama)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: position within the frame plus value/pending registers
  int          mp;
  logic [15:0] m_shadow;
  logic [15:0] m_pend_val;
  logic        m_pend;
  bit          mvalid = 1'b0;
  logic        sup_cur = 1'b0;

  function automatic void chk(string nm, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endfunction

  task automatic check_model();
    int d, w;
    logic lit;
    logic [3:0] ea, en;
    d   = mp / SLOT;
    w   = mp % SLOT;
    lit = habilitar && (w >= BL) &&
          !(suprimir_ceros && d > 0 && (m_shadow >> (4 * d)) == 16'h0);
    ea  = lit ? 4'(1 << d) : 4'h0;
    en  = 4'((m_shadow >> (4 * d)) & 16'hF);
    chk("model_anodo", 16'(anodo), 16'(ea));
    chk("model_numero", 16'(numeroMostrar), 16'(en));
    chk("model_ocupado", 16'(ocupado), 16'(m_pend));
    chk("model_fin", 16'(fin_trama), 16'(habilitar && mp == FRAME - 1));
  endtask

  task automatic model_update();
    logic wr;
    if (rst) begin
      mp = 0; m_shadow = '0; m_pend_val = '0; m_pend = 1'b0; mvalid = 1'b1;
    end else if (mvalid) begin
      wr = !habilitar || (mp == FRAME - 1);
      if (actualizar) m_pend_val = valor;
      if (wr && actualizar) begin
        m_shadow = valor; m_pend = 1'b0;
      end else if (wr && m_pend) begin
        m_shadow = m_pend_val; m_pend = 1'b0;
      end else if (actualizar) begin
        m_pend = 1'b1;
      end
      mp = habilitar ? (mp + 1) % FRAME : 0;
    end
  endtask

  task automatic apply(input logic r, input logic h, input logic a, input logic s,
                       input logic [15:0] v);
    @(negedge clk);
    rst = r; habilitar = h; actualizar = a; suprimir_ceros = s; valor = v;
    #1;
    if (mvalid) check_model();
  endtask

  task automatic commit();
    @(posedge clk);
    model_update();
  endtask

  task automatic step(input logic r, input logic h, input logic a, input logic s,
                      input logic [15:0] v);
    apply(r, h, a, s, v);
    commit();
  endtask

  task automatic wait_phase(input int target);
    for (int k = 0; k < FRAME + 2 && mp != target; k++) step(1'b0, 1'b1, 1'b0, sup_cur, 16'h0);
    if (mp != target) begin
      checks++; errors++;
      $display("FAIL wait_phase: phase %0d never reached (at %0d)", target, mp);
    end
  endtask

  typedef struct {
    logic        r, h, a, s;
    logic [15:0] v;
    bit          c;
    logic [3:0]  ea, en;
    logic        eo, ef;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int fin_cnt, last_fin, saw_a, saw_f;
    logic [3:0] ea;

    rst = 1'b0; habilitar = 1'b0; actualizar = 1'b0; suprimir_ceros = 1'b0; valor = '0;

    //           r     h     a     s     valor     c     anodo  num   ocup  fin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h2, 4'h0, 1'b1, 1'b0};

    // Reset, first strobe and start of the first frame
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].r, tbl[i].h, tbl[i].a, tbl[i].s, tbl[i].v);
      if (tbl[i].c) begin
        chk($sformatf("tbl%0d_anodo", i), 16'(anodo), 16'(tbl[i].ea));
        chk($sformatf("tbl%0d_numero", i), 16'(numeroMostrar), 16'(tbl[i].en));
        chk($sformatf("tbl%0d_ocupado", i), 16'(ocupado), 16'(tbl[i].eo));
        chk($sformatf("tbl%0d_fin", i), 16'(fin_trama), 16'(tbl[i].ef));
      end
      commit();
    end

    // ocupado holds until the first wrap, then 1234 scans as 4,3,2,1
    for (int k = 0; k < FRAME && mp != FRAME - 1; k++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      chk("t1_busy", 16'(ocupado), 16'h1);
      commit();
    end
    apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("t1_wrap_fin", 16'(fin_trama), 16'h1);
    chk("t1_wrap_busy", 16'(ocupado), 16'h1);
    commit();
    for (int d = 0; d < N; d++) begin
      for (int w = 0; w < SLOT; w++) begin
        apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        ea = (w >= BL) ? 4'(1 << d) : 4'h0;
        chk($sformatf("t1_anodo_d%0d_w%0d", d, w), 16'(anodo), 16'(ea));
        chk($sformatf("t1_numero_d%0d", d), 16'(numeroMostrar), 16'(4 - d));
        chk("t1_idle", 16'(ocupado), 16'h0);
        commit();
      end
    end

    // Free-run: fin_trama period and alignment with the last digit
    fin_cnt = 0; last_fin = -1;
    for (int k = 0; k < 3 * FRAME; k++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      if (fin_trama === 1'b1) begin
        chk("t2_fin_anodo", 16'(anodo), 16'h8);
        if (last_fin >= 0) chk("t2_fin_period", 16'(k - last_fin), 16'(FRAME));
        last_fin = k;
        fin_cnt++;
      end
      commit();
    end
    chk("t2_fin_count", 16'(fin_cnt), 16'h3);

    // Two strobes in one frame: only the last value is ever shown
    wait_phase(3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'hAAAA);
    wait_phase(10);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h00F0);
    saw_a = 0; saw_f = 0;
    for (int k = 0; k < 3 * FRAME; k++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      if (numeroMostrar === 4'hA) saw_a++;
      if (numeroMostrar === 4'hF) saw_f++;
      commit();
    end
    chk("t3_never_aaaa", 16'(saw_a), 16'h0);
    chk("t3_f_shown", 16'(saw_f > 0), 16'h1);

    // Leading-zero suppression on 0005: only digit 0 lights
    sup_cur = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0005);
    wait_phase(0);
    for (int d = 0; d < N; d++) begin
      for (int w = 0; w < SLOT; w++) begin
        apply(1'b0, 1'b1, 1'b0, 1'b1, 16'h0);
        ea = (d == 0 && w >= BL) ? 4'h1 : 4'h0;
        chk($sformatf("t4_anodo_d%0d_w%0d", d, w), 16'(anodo), 16'(ea));
        chk("t4_fin", 16'(fin_trama), 16'(d == N - 1 && w == SLOT - 1));
        commit();
      end
    end
    sup_cur = 1'b0;

    // Reset mid digit 2 ON with an update pending
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0300);
    wait_phase(0);
    wait_phase(5);
    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h00AB);
    wait_phase(2 * SLOT + 3);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("t5_pre_numero", 16'(numeroMostrar), 16'h3);
    chk("t5_pre_busy", 16'(ocupado), 16'h1);
    commit();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      chk($sformatf("t5_anodo_%0d", k), 16'(anodo), (k == 2) ? 16'h1 : 16'h0);
      chk("t5_numero", 16'(numeroMostrar), 16'h0);
      chk("t5_busy", 16'(ocupado), 16'h0);
      commit();
    end

    // Disable for 10 cycles mid-frame with a strobe in the gap
    wait_phase(8);
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 1'b0, (k == 3), 1'b0, 16'h9876);
      chk($sformatf("t6_off_anodo_%0d", k), 16'(anodo), 16'h0);
      chk("t6_off_fin", 16'(fin_trama), 16'h0);
      if (k == 4) chk("t6_busy_clear", 16'(ocupado), 16'h0);
      commit();
    end
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      chk($sformatf("t6_on_anodo_%0d", k), 16'(anodo), (k == 2) ? 16'h1 : 16'h0);
      chk("t6_on_numero", 16'(numeroMostrar), 16'h6);
      commit();
    end

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      logic [15:0] v;
      if ($urandom_range(49) == 0) sup_cur = ~sup_cur;
      v = 16'($urandom);
      v = v >> (4 * $urandom_range(3));
      step(($urandom_range(299) == 0), ($urandom_range(24) != 0),
           ($urandom_range(14) == 0), sup_cur, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
